video_timing_gen: RTL and testbench

// Raster timing generator driving the video output path (vo_hsync, vo_vsync, vo_blank_)
// and supplying pixel coordinates to the pixel pipeline that computes vo_r/g/b.

---
 rtl/video_timing_gen_if.sv | 30 +++
 rtl/video_timing_gen.sv | 134 +++++++++++++
 tb/tb_video_timing_gen.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// Video timing interface: bundles the pixel-rate enable with the sync, blanking,
// coordinate and frame-marker outputs of the raster timing generator.
//   pix_en       pixel-rate enable (consumer -> generator)
//   hsync/vsync  sync levels, polarity set by the generator parameters
//   blank_       1 = active video, 0 = blanking
//   pixel_x/y    counter values decoded this cycle (12 bit)
//   line_start   1-cycle pulse at h_cnt == 0
//   frame_start  1-cycle pulse at (h_cnt, v_cnt) == (0, 0)
//   frame_cnt    frames started since reset (16 bit, wrapping)
interface video_timing_gen_if;
  logic        pix_en;
  logic        hsync;
  logic        vsync;
  logic        blank_;
  logic [11:0] pixel_x;
  logic [11:0] pixel_y;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_cnt;

  modport master (
    input  pix_en,
    output hsync, vsync, blank_, pixel_x, pixel_y, line_start, frame_start, frame_cnt
  );

  modport slave (
    output pix_en,
    input  hsync, vsync, blank_, pixel_x, pixel_y, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator. Walks a programmable horizontal/vertical raster one
// pixel per pix_en cycle and produces registered sync, blanking, coordinate and
// frame-marker outputs describing the counter state before each enabled edge.
// Ports:
//   clock  single clock, all state on posedge
//   reset  synchronous, active-high; has priority over pix_en
//   vo     video_timing_gen_if.master (pix_en in; sync/blank/coords/markers out)
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  video_timing_gen_if.master vo
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_total_check
    $error("video_timing_gen: H_TOTAL and V_TOTAL must be <= 4096");
  end

  // Thresholds are 13 bits wide so a sync pulse ending exactly at a total of
  // 4096 still compares correctly against the 12-bit counters.
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [12:0] H_ACT_E  = 13'(H_ACTIVE);
  localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT_E  = 13'(V_ACTIVE);
  localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        blank_q, blank_d;
  logic [11:0] pixel_x_q, pixel_x_d;
  logic [11:0] pixel_y_q, pixel_y_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic [12:0] h_ext;
  logic [12:0] v_ext;
  logic        h_sync_act;
  logic        v_sync_act;
  logic        frame_hit;

  always_comb begin
    h_ext      = {1'b0, h_cnt_q};
    v_ext      = {1'b0, v_cnt_q};
    h_sync_act = (h_ext >= HS_START) && (h_ext < HS_END);
    v_sync_act = (v_ext >= VS_START) && (v_ext < VS_END);
    frame_hit  = (h_cnt_q == '0) && (v_cnt_q == '0);

    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blank_d       = blank_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    // Markers are single-cycle: they drop on any edge that does not decode them.
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    if (vo.pix_en) begin
      // Outputs take the decode of the pre-increment counters.
      hsync_d       = h_sync_act ? HS_POL : ~HS_POL;
      vsync_d       = v_sync_act ? VS_POL : ~VS_POL;
      blank_d       = (h_ext < H_ACT_E) && (v_ext < V_ACT_E);
      pixel_x_d     = h_cnt_q;
      pixel_y_d     = v_cnt_q;
      line_start_d  = (h_cnt_q == '0);
      frame_start_d = frame_hit;
      frame_cnt_d   = frame_cnt_q + 16'(frame_hit);

      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 12'd1;
      end else begin
        h_cnt_d = h_cnt_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      blank_q       <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign vo.hsync       = hsync_q;
  assign vo.vsync       = vsync_q;
  assign vo.blank_      = blank_q;
  assign vo.pixel_x     = pixel_x_q;
  assign vo.pixel_y     = pixel_y_q;
  assign vo.line_start  = line_start_q;
  assign vo.frame_start = frame_start_q;
  assign vo.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  logic clock = 1'b0;
  logic reset;
  logic reset_d;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  video_timing_gen_if vif ();
  video_timing_gen_if vif_d ();

  // Small raster: H 8/2/3/3 (16), V 4/1/2/1 (8), active-high syncs.
  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .vo   (vif.master)
  );

  // Default 640x480 raster, active-low syncs.
  video_timing_gen dut_d (
    .clock(clock),
    .reset(reset_d),
    .vo   (vif_d.master)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_raster();
    reset      = 1'b1;
    vif.pix_en = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    vif.pix_en = 1'b1;
    tick();
    tick();
    checks++; if (vif.hsync !== 1'b0) begin errors++; $display("FAIL reset_hsync got %b expected 0", vif.hsync); end
    checks++; if (vif.vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync got %b expected 0", vif.vsync); end
    checks++; if (vif.blank_ !== 1'b0) begin errors++; $display("FAIL reset_blank got %b expected 0", vif.blank_); end
    checks++; if (vif.pixel_x !== 12'd0) begin errors++; $display("FAIL reset_pixel_x got %0d expected 0", vif.pixel_x); end
    checks++; if (vif.pixel_y !== 12'd0) begin errors++; $display("FAIL reset_pixel_y got %0d expected 0", vif.pixel_y); end
    checks++; if (vif.line_start !== 1'b0) begin errors++; $display("FAIL reset_line_start got %b expected 0", vif.line_start); end
    checks++; if (vif.frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b expected 0", vif.frame_start); end
    checks++; if (vif.frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d expected 0", vif.frame_cnt); end
  endtask

  task automatic test_blank_pixel_x();
    start_raster();
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (vif.blank_ !== (k <= 8)) begin
        errors++; $display("FAIL blank edge %0d got %b expected %b", k, vif.blank_, (k <= 8));
      end
      checks++;
      if (vif.pixel_x !== 12'(k - 1)) begin
        errors++; $display("FAIL pixel_x edge %0d got %0d expected %0d", k, vif.pixel_x, k - 1);
      end
    end
  endtask

  task automatic test_hsync();
    logic prev = 1'b0;
    int   rises = 0;
    start_raster();
    for (int k = 1; k <= 128; k++) begin
      tick();
      if (vif.hsync && !prev) rises++;
      prev = vif.hsync;
      if (k >= 10 && k <= 14) begin
        checks++;
        if (vif.hsync !== (k >= 11 && k <= 13)) begin
          errors++; $display("FAIL hsync edge %0d got %b expected %b", k, vif.hsync, (k >= 11 && k <= 13));
        end
      end
      if (k == 1 || k == 16 || k == 17) begin
        checks++;
        if (vif.line_start !== (k != 16)) begin
          errors++; $display("FAIL line_start edge %0d got %b expected %b", k, vif.line_start, (k != 16));
        end
      end
      if (k == 17) begin
        checks++;
        if (vif.pixel_y !== 12'd1) begin
          errors++; $display("FAIL pixel_y edge 17 got %0d expected 1", vif.pixel_y);
        end
      end
    end
    checks++;
    if (rises !== 8) begin errors++; $display("FAIL hsync_rises_per_frame got %0d expected 8", rises); end
  endtask

  task automatic test_vsync_frames();
    logic prev = 1'b0;
    int   nrise = 0;
    int   rise_at [3];
    start_raster();
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (vif.vsync && !prev) begin
        if (nrise < 3) rise_at[nrise] = k;
        nrise++;
      end
      prev = vif.vsync;
      if (k == 80 || k == 81 || k == 112 || k == 113) begin
        checks++;
        if (vif.vsync !== (k == 81 || k == 112)) begin
          errors++; $display("FAIL vsync edge %0d got %b expected %b", k, vif.vsync, (k == 81 || k == 112));
        end
      end
      if (k == 1 || k == 2 || k == 129 || k == 257) begin
        checks++;
        if (vif.frame_start !== (k != 2)) begin
          errors++; $display("FAIL frame_start edge %0d got %b expected %b", k, vif.frame_start, (k != 2));
        end
      end
      if (k == 1 || k == 128 || k == 129 || k == 257) begin
        int exp_fc;
        exp_fc = (k <= 128) ? 1 : (k < 257) ? 2 : 3;
        checks++;
        if (vif.frame_cnt !== 16'(exp_fc)) begin
          errors++; $display("FAIL frame_cnt edge %0d got %0d expected %0d", k, vif.frame_cnt, exp_fc);
        end
      end
    end
    checks++;
    if (nrise !== 3) begin errors++; $display("FAIL vsync_rise_count got %0d expected 3", nrise); end
    if (nrise >= 3) begin
      checks++; if (rise_at[0] !== 81)  begin errors++; $display("FAIL vsync_rise_0 got %0d expected 81", rise_at[0]); end
      checks++; if (rise_at[1] !== 209) begin errors++; $display("FAIL vsync_rise_1 got %0d expected 209", rise_at[1]); end
      checks++; if (rise_at[2] !== 337) begin errors++; $display("FAIL vsync_rise_2 got %0d expected 337", rise_at[2]); end
    end
  endtask

  task automatic test_pix_en_toggle();
    logic prev = 1'b0;
    int   first_rise = -1;
    start_raster();
    for (int e = 1; e <= 300; e++) begin
      int n;
      int h;
      vif.pix_en = (e % 2 == 1);
      tick();
      n = (e + 1) / 2;
      h = (n - 1) % 16;
      if (vif.vsync && !prev && first_rise < 0) first_rise = e;
      prev = vif.vsync;
      if (e <= 40) begin
        checks++;
        if (vif.pixel_x !== 12'(h)) begin
          errors++; $display("FAIL toggle_pixel_x edge %0d got %0d expected %0d", e, vif.pixel_x, h);
        end
        checks++;
        if (vif.blank_ !== (h < 8)) begin
          errors++; $display("FAIL toggle_blank edge %0d got %b expected %b", e, vif.blank_, (h < 8));
        end
        checks++;
        if (vif.hsync !== (h >= 10 && h <= 12)) begin
          errors++; $display("FAIL toggle_hsync edge %0d got %b expected %b", e, vif.hsync, (h >= 10 && h <= 12));
        end
        checks++;
        if (vif.line_start !== ((e % 2 == 1) && h == 0)) begin
          errors++; $display("FAIL toggle_line_start edge %0d got %b expected %b", e, vif.line_start, ((e % 2 == 1) && h == 0));
        end
        checks++;
        if (vif.frame_start !== (e == 1)) begin
          errors++; $display("FAIL toggle_frame_start edge %0d got %b expected %b", e, vif.frame_start, (e == 1));
        end
        checks++;
        if (vif.frame_cnt !== 16'd1) begin
          errors++; $display("FAIL toggle_frame_cnt edge %0d got %0d expected 1", e, vif.frame_cnt);
        end
      end
    end
    checks++;
    if (first_rise !== 161) begin errors++; $display("FAIL toggle_vsync_rise got %0d expected 161", first_rise); end
    vif.pix_en = 1'b1;
  endtask

  task automatic test_reset_mid_vsync();
    logic prev = 1'b0;
    int   first_rise = -1;
    start_raster();
    for (int k = 1; k <= 89; k++) tick();
    checks++;
    if (vif.vsync !== 1'b1) begin errors++; $display("FAIL mid_vsync_before_reset got %b expected 1", vif.vsync); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (vif.vsync !== 1'b0) begin errors++; $display("FAIL mid_reset_vsync got %b expected 0", vif.vsync); end
    checks++; if (vif.hsync !== 1'b0) begin errors++; $display("FAIL mid_reset_hsync got %b expected 0", vif.hsync); end
    checks++; if (vif.blank_ !== 1'b0) begin errors++; $display("FAIL mid_reset_blank got %b expected 0", vif.blank_); end
    checks++; if (vif.pixel_x !== 12'd0) begin errors++; $display("FAIL mid_reset_pixel_x got %0d expected 0", vif.pixel_x); end
    checks++; if (vif.pixel_y !== 12'd0) begin errors++; $display("FAIL mid_reset_pixel_y got %0d expected 0", vif.pixel_y); end
    checks++; if (vif.frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_frame_cnt got %0d expected 0", vif.frame_cnt); end
    checks++; if (vif.frame_start !== 1'b0) begin errors++; $display("FAIL mid_reset_frame_start got %b expected 0", vif.frame_start); end
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (vif.vsync && !prev && first_rise < 0) first_rise = k;
      prev = vif.vsync;
      if (k == 1) begin
        checks++;
        if (vif.frame_cnt !== 16'd1) begin errors++; $display("FAIL mid_restart_frame_cnt got %0d expected 1", vif.frame_cnt); end
      end
    end
    checks++;
    if (first_rise !== 81) begin errors++; $display("FAIL mid_restart_vsync_rise got %0d expected 81", first_rise); end
  endtask

  task automatic test_default_line();
    logic prev = 1'b1;
    int   falls = 0;
    reset_d      = 1'b1;
    vif_d.pix_en = 1'b1;
    tick();
    reset_d = 1'b0;
    for (int k = 1; k <= 1700; k++) begin
      tick();
      if (!vif_d.hsync && prev) falls++;
      prev = vif_d.hsync;
      if (k == 640 || k == 641) begin
        checks++;
        if (vif_d.blank_ !== (k == 640)) begin
          errors++; $display("FAIL dflt_blank edge %0d got %b expected %b", k, vif_d.blank_, (k == 640));
        end
      end
      if (k == 656 || k == 657 || k == 752 || k == 753) begin
        checks++;
        if (vif_d.hsync !== (k == 656 || k == 753)) begin
          errors++; $display("FAIL dflt_hsync edge %0d got %b expected %b", k, vif_d.hsync, (k == 656 || k == 753));
        end
      end
      if (k == 800) begin
        checks++;
        if (vif_d.pixel_x !== 12'd799) begin errors++; $display("FAIL dflt_pixel_x edge 800 got %0d expected 799", vif_d.pixel_x); end
        checks++;
        if (vif_d.line_start !== 1'b0) begin errors++; $display("FAIL dflt_line_start edge 800 got %b expected 0", vif_d.line_start); end
      end
      if (k == 801) begin
        checks++;
        if (vif_d.pixel_y !== 12'd1) begin errors++; $display("FAIL dflt_pixel_y edge 801 got %0d expected 1", vif_d.pixel_y); end
        checks++;
        if (vif_d.line_start !== 1'b1) begin errors++; $display("FAIL dflt_line_start edge 801 got %b expected 1", vif_d.line_start); end
      end
      if (k == 1700) begin
        checks++;
        if (vif_d.vsync !== 1'b1) begin errors++; $display("FAIL dflt_vsync_idle got %b expected 1", vif_d.vsync); end
      end
    end
    checks++;
    if (falls !== 2) begin errors++; $display("FAIL dflt_hsync_pulses got %0d expected 2", falls); end
  endtask

  initial begin
    reset        = 1'b1;
    reset_d      = 1'b1;
    vif.pix_en   = 1'b0;
    vif_d.pix_en = 1'b0;
    test_reset();
    test_blank_pixel_x();
    test_hsync();
    test_vsync_frames();
    test_pix_en_toggle();
    test_reset_mid_vsync();
    test_default_line();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
